// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one single-port synchronous RAM.
// Accesses are serialised with req/gnt; reads return data with a per-port rvalid pulse.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            r_state, w_state_nxt;
  logic              r_port, w_port_nxt;
  logic              r_last, w_last_nxt;
  logic              w_win;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic [1:0]        r_rvalid, w_rvalid_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_port_nxt      = r_port;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_gnt_nxt       = '0;
    w_rvalid_nxt    = '0;
    w_rdata_nxt     = r_rdata;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    // On a tie the port that did not win last time goes next.
    w_win = (req == 2'b11) ? ~r_last : req[1];
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          w_state_nxt     = ISSUE;
          w_port_nxt      = w_win;
          w_last_nxt      = w_win;
          w_gnt_nxt       = w_win ? 2'b10 : 2'b01;
          w_mem_en_nxt    = 1'b1;
          w_mem_we_nxt    = we[w_win];
          w_mem_addr_nxt  = w_win ? addr1 : addr0;
          w_mem_wdata_nxt = w_win ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        if (r_mem_we) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = LAT;
        end
      end
      WAIT: begin
        // Firing on the 1->0 step lands rvalid MEM_LAT+2 cycles after the req sample.
        if (r_cnt <= 4'd1) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_rvalid_nxt = r_port ? 2'b10 : 2'b01;
          w_rdata_nxt  = mem_rdata;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_port      <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_port      <= w_port_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign busy      = (r_state != IDLE);
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 4, 15) share one stimulus stream and are
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] we  = '0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic [1:0] gnt_a [3];
  logic [1:0] rvalid_a [3];
  logic [7:0] rdata_a [3];
  logic       busy_a [3];
  logic       mem_en_a [3];
  logic       mem_we_a [3];
  logic [7:0] mem_addr_a [3];
  logic [7:0] mem_wdata_a [3];
  logic [7:0] mem_rdata_a [3];

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 15);
  endfunction

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h, want 0x%0h", nm, inst, cyc, act, exp);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g
    localparam int LAT = (i == 0) ? 1 : ((i == 1) ? 4 : 15);

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt      (gnt_a[i]),
      .rvalid   (rvalid_a[i]),
      .rdata    (rdata_a[i]),
      .busy     (busy_a[i]),
      .mem_en   (mem_en_a[i]),
      .mem_we   (mem_we_a[i]),
      .mem_addr (mem_addr_a[i]),
      .mem_wdata(mem_wdata_a[i]),
      .mem_rdata(mem_rdata_a[i])
    );

    // RAM: data valid only in the single cycle LAT cycles after mem_en, inverted garbage otherwise
    logic [7:0] ram [256];
    int         rc   = 0;
    logic [7:0] rd_q = '0;
    assign mem_rdata_a[i] = (rc == 1) ? rd_q : ~rd_q;
    initial for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'h5A;
    always @(posedge clk) begin
      if (mem_en_a[i] && mem_we_a[i]) ram[mem_addr_a[i]] <= mem_wdata_a[i];
      if (mem_en_a[i] && !mem_we_a[i]) begin
        rd_q <= ram[mem_addr_a[i]];
        rc   <= LAT;
      end else if (rc > 0) begin
        rc <= rc - 1;
      end
    end

    // Transaction-level model: absolute cycle numbers of the grant, rvalid and next free cycle
    logic [7:0] mref [256];
    int         t = 0, free_at = 0, g_cyc = -1, rv_cyc = -1;
    logic [1:0] g_hot = '0, rv_hot = '0;
    logic [7:0] rv_dat = '0, m_rdata = '0, m_addr = '0, m_wdata = '0, p_a = '0, p_d = '0;
    logic       m_we = 1'b0, m_last = 1'b1, p_w = 1'b0;
    initial for (int a = 0; a < 256; a++) mref[a] = 8'(a) ^ 8'h5A;

    initial forever begin : mdl
      int w;
      @(posedge clk);
      if (rst) begin
        g_cyc = -1; rv_cyc = -1; m_rdata = '0; m_addr = '0; m_wdata = '0;
        m_we = 1'b0; m_last = 1'b1; p_w = 1'b0; free_at = t + 1;
      end else begin
        if (p_w && t == g_cyc) begin
          mref[p_a] = p_d;
          p_w = 1'b0;
        end
        if (t >= free_at && req != 2'b00) begin
          w = (req == 2'b11) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
          m_last  = (w == 1);
          g_cyc   = t + 1;
          g_hot   = (w == 1) ? 2'b10 : 2'b01;
          m_we    = we[w];
          m_addr  = (w == 1) ? addr1 : addr0;
          m_wdata = (w == 1) ? wdata1 : wdata0;
          if (m_we) begin
            p_w = 1'b1; p_a = m_addr; p_d = m_wdata;
            free_at = t + 2;
          end else begin
            rv_cyc  = t + 2 + LAT;
            rv_hot  = g_hot;
            rv_dat  = mref[m_addr];
            free_at = rv_cyc;
          end
        end
      end
      t++;
      if (t == rv_cyc) m_rdata = rv_dat;
    end

    initial forever begin : cmp
      @(negedge clk);
      chk(i, "gnt",       32'(gnt_a[i]),    32'((t == g_cyc) ? g_hot : 2'b00));
      chk(i, "rvalid",    32'(rvalid_a[i]), 32'((t == rv_cyc) ? rv_hot : 2'b00));
      chk(i, "rdata",     32'(rdata_a[i]),  32'(m_rdata));
      chk(i, "busy",      32'(busy_a[i]),   32'((g_cyc >= 0) && (t >= g_cyc) && (t < free_at)));
      chk(i, "mem_en",    32'(mem_en_a[i]), 32'(t == g_cyc));
      chk(i, "mem_we",    32'(mem_we_a[i]), 32'(m_we));
      chk(i, "mem_addr",  32'(mem_addr_a[i]),  32'(m_addr));
      chk(i, "mem_wdata", 32'(mem_wdata_a[i]), 32'(m_wdata));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_gnt",    32'(gnt_a[k]),    32'd0);
      chk(k, "rst_rvalid", 32'(rvalid_a[k]), 32'd0);
      chk(k, "rst_rdata",  32'(rdata_a[k]),  32'd0);
      chk(k, "rst_busy",   32'(busy_a[k]),   32'd0);
      chk(k, "rst_mem_en", 32'(mem_en_a[k]), 32'd0);
      chk(k, "rst_mem_we", 32'(mem_we_a[k]), 32'd0);
      chk(k, "rst_addr",   32'(mem_addr_a[k]),  32'd0);
      chk(k, "rst_wdata",  32'(mem_wdata_a[k]), 32'd0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int j = 0; j < 40 && !idle; j++) begin
      @(negedge clk);
      idle = !busy_a[0] && !busy_a[1] && !busy_a[2];
    end
    chk(-1, "idle_timeout", 32'(idle), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int c0, cr, m, l, ndone, nrv;
    int cnt0 [3], cnt1 [3], bad [3], lastc [3], rv_at [3], busy_n [3];
    logic [1:0] lastg [3];
    logic [1:0] gv;
    bit seen [3];

    repeat (3) @(negedge clk);
    // Reset release with both ports requesting: port 0 wins the first tie
    req = 2'b11; we = 2'b00; addr0 = 8'h01; addr1 = 8'h02;
    c0 = cyc;
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk(k, "first_gnt", 32'(gnt_a[k]), 32'h1);
    do_reset();
    cr = cyc;

    // Contention after reset, reads of 8'h01 (port 0) and 8'h02 (port 1)
    for (int k = 0; k < 3; k++) seen[k] = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk(0, "cont_gnt",    32'(gnt_a[0]),    32'((j == 1) ? 2'b01 : ((j == 4) ? 2'b10 : 2'b00)));
      chk(0, "cont_rvalid", 32'(rvalid_a[0]), 32'((j == 3) ? 2'b01 : ((j == 6) ? 2'b10 : 2'b00)));
      if (j == 3) chk(0, "cont_rdata0", 32'(rdata_a[0]), 32'h5B);
      if (j == 6) chk(0, "cont_rdata1", 32'(rdata_a[0]), 32'h58);
      if (j == 1) req[0] = 1'b0;
      for (int k = 0; k < 3; k++) if (gnt_a[k][1]) seen[k] = 1'b1;
    end
    chk(-1, "cont_timing", 32'(cyc - cr), 32'd6);
    ndone = 0;
    for (int j = 0; j < 40 && ndone < 3; j++) begin
      @(negedge clk);
      ndone = 0;
      for (int k = 0; k < 3; k++) begin
        if (gnt_a[k][1]) seen[k] = 1'b1;
        if (seen[k]) ndone++;
      end
    end
    chk(-1, "cont_all_granted", 32'(ndone), 32'd3);
    req = 2'b00;
    wait_idle();

    // Port 0 writes 8'hA5 to 8'h10
    req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(k, "wr_gnt",   32'(gnt_a[k]),      32'h1);
      chk(k, "wr_we",    32'(mem_we_a[k]),   32'h1);
      chk(k, "wr_addr",  32'(mem_addr_a[k]), 32'h10);
      chk(k, "wr_wdata", 32'(mem_wdata_a[k]), 32'hA5);
    end
    req = 2'b00; we = 2'b00;
    wait_idle();

    // Port 0 reads it back: rvalid exactly 3 cycles after the sample with MEM_LAT=1
    req = 2'b01; we = 2'b00; addr0 = 8'h10; m = cyc;
    @(negedge clk); req = 2'b00;
    @(negedge clk); chk(0, "rd_early", 32'(rvalid_a[0]), 32'h0);
    @(negedge clk);
    chk(0, "rd_rvalid", 32'(rvalid_a[0]), 32'h1);
    chk(0, "rd_rdata",  32'(rdata_a[0]),  32'hA5);
    chk(0, "rd_cycle",  32'(cyc - m),     32'd3);
    wait_idle();

    // Fairness: continuous writes from both ports
    req = 2'b11; we = 2'b11; addr0 = 8'h20; addr1 = 8'h21;
    wdata0 = 8'($urandom); wdata1 = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      cnt0[k] = 0; cnt1[k] = 0; bad[k] = 0; lastc[k] = -1; lastg[k] = 2'b00;
    end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        gv = gnt_a[k];
        if (gv != 2'b00) begin
          if (gv == 2'b01) cnt0[k]++;
          else if (gv == 2'b10) cnt1[k]++;
          else bad[k]++;
          if (lastc[k] >= 0 && (gv == lastg[k] || cyc - lastc[k] != 2)) bad[k]++;
          lastg[k] = gv; lastc[k] = cyc;
        end
      end
      if (j == 20) begin req = 2'b00; we = 2'b00; end
    end
    for (int k = 0; k < 3; k++) begin
      chk(k, "fair_cnt0", 32'(cnt0[k]), 32'd5);
      chk(k, "fair_cnt1", 32'(cnt1[k]), 32'd5);
      chk(k, "fair_alternation", 32'(bad[k]), 32'd0);
    end
    wait_idle();

    // Latency sweep: one port-1 read of 8'h05 seen by all three latencies
    req = 2'b10; we = 2'b00; addr1 = 8'h05; l = cyc;
    for (int k = 0; k < 3; k++) begin rv_at[k] = -1; busy_n[k] = 0; end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) req = 2'b00;
      for (int k = 0; k < 3; k++) begin
        if (busy_a[k]) busy_n[k]++;
        if (rvalid_a[k] == 2'b10 && rv_at[k] < 0) rv_at[k] = cyc - l;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk(k, "lat_rvalid_cycle", 32'(rv_at[k]),  32'(lat_of(k) + 2));
      chk(k, "lat_busy_cycles",  32'(busy_n[k]), 32'(lat_of(k) + 1));
      chk(k, "lat_rdata",        32'(rdata_a[k]), 32'h5F);
    end
    wait_idle();

    // Reset two cycles into WAIT of a MEM_LAT=4 read
    req = 2'b10; we = 2'b00; addr1 = 8'h30;
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    nrv = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (rvalid_a[1] != 2'b00) nrv++;
    end
    chk(1, "rst_dropped_rvalid", 32'(nrv), 32'd0);
    req = 2'b10; addr1 = 8'h30; l = cyc; rv_at[1] = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 1) req = 2'b00;
      if (rvalid_a[1] == 2'b10 && rv_at[1] < 0) begin
        rv_at[1] = cyc - l;
        chk(1, "post_rst_rdata", 32'(rdata_a[1]), 32'h6A);
      end
    end
    chk(1, "post_rst_cycle", 32'(rv_at[1]), 32'd6);
    wait_idle();

    // Random traffic with occasional reset pulses
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        @(negedge clk);
        req    = 2'($urandom);
        we     = 2'($urandom);
        addr0  = {4'h0, 4'($urandom)};
        addr1  = {4'h0, 4'($urandom)};
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
      end
    end
    req = 2'b00; we = 2'b00;
    wait_idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the 8-bit CPU's single-port synchronous program/data RAM between the CPU core (port 0) and the program loader/DMA engine (port 1). It sits between the CPU's memory interface and the RAM instance inside the CPU top level. It serialises accesses with a req/gnt handshake and returns read data with a per-port valid pulse.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- MEM_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..15
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  2  per-port access request; bit 0 = CPU, bit 1 = loader
- we  in  2  per-port write enable, qualified by req
- addr0, addr1  in  ADDR_W  per-port address
- wdata0, wdata1  in  DATA_W  per-port write data
- gnt  out  2  one-cycle grant pulse, one-hot or zero
- rvalid  out  2  one-cycle read-data-valid pulse, one-hot or zero
- rdata  out  DATA_W  shared read-data bus, valid when any rvalid bit is set; holds its last value otherwise
- busy  out  1  high whenever state is not IDLE
- mem_en  out  1  RAM access strobe, one cycle per transaction
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: req sampled only here. If no bit is set, stay in IDLE.
  - If exactly one bit is set, that port wins.
  - If both bits are set, the port not granted most recently wins, and the last-grant pointer updates.
  - On the winning edge: go to ISSUE, register gnt[w]=1, mem_en=1, and latch we[w]/addr[w]/wdata[w] into mem_we/mem_addr/mem_wdata.
- ISSUE (one cycle): gnt and mem_en are high.
  - Write: go to IDLE.
  - Read: go to WAIT and load the latency counter with MEM_LAT.
  - gnt and mem_en clear on leaving ISSUE.
- WAIT: the counter decrements each cycle. On the edge where the counter reaches 0:
  - capture mem_rdata into rdata;
  - pulse rvalid[w] for one cycle;
  - go to IDLE.
- mem_addr, mem_we and mem_wdata hold their latched values until the next grant.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Drop or update req on the edge that ends the gnt cycle.
  - Dropping req before gnt is legal; the request is simply not served.
  - A req held during ISSUE or WAIT is ignored until IDLE.
- Port w is registered at grant. rvalid always returns to the granted port, even if that port drops req.
- Arithmetic: the counter is 4 bits. A write never produces rvalid.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE. The pointer is set so that port 0 wins the first tie.
- req sampled high in cycle N (IDLE) gives gnt and mem_en in cycle N+1.
- Write: back in IDLE in cycle N+2. The earliest next grant is in N+3, which gives 2 cycles per write.
- Read: rvalid and rdata appear in cycle N+2+MEM_LAT, with state IDLE in that same cycle. With MEM_LAT=1, rvalid is in N+3.
- Back-to-back contention alternates grants 0,1,0,1 with no port starved. The worst-case wait is one transaction of the other port.
- rst asserted mid-transaction (ISSUE or WAIT) takes effect immediately and asynchronously:
  - all outputs return to reset values;
  - the in-flight read is dropped and never produces rvalid;
  - the pointer resets.
- After rst is released, the first arbitration is on the first rising edge with req sampled in IDLE.

## Test plan
- Reset: assert rst mid-cycle with req=2'b11 -> all outputs 0 immediately; after release, port 0 is granted first.
- Single write then read, MEM_LAT=1:
  - port 0 writes 8'hA5 to 8'h10 -> gnt[0] in N+1 with mem_we=1, mem_addr=8'h10, mem_wdata=8'hA5;
  - port 0 then reads 8'h10 -> rvalid[0]=1 and rdata=8'hA5 exactly 3 cycles after the read req is sampled.
- Contention: both ports hold req for reads of 8'h01 (port 0) and 8'h02 (port 1) -> grants 0 then 1; rvalid[0] precedes rvalid[1]; rdata matches the RAM contents; no overlap of mem_en.
- Fairness: both ports issue continuous writes for 10 transactions -> exactly 5 grants each, strictly alternating, one grant every 2 cycles.
- Reset mid-read: with MEM_LAT=4, assert rst 2 cycles into WAIT -> no rvalid; busy=0; the next read of port 1 completes normally.
- Latency sweep: MEM_LAT in {1,4,15} -> rvalid exactly MEM_LAT+2 cycles after the req sample edge; busy high throughout.
